// File: rtl/maxnet_pkg.sv
// Shared constants and FSM state encoding for the Maxnet arithmetic-sharing blocks.
package maxnet_pkg;
  localparam int FP_W = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after rr_ptr wins, cyclically.
// Latency: purely combinational. Backpressure: grant/any_grant forced low when en=0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);
  logic [ID_W-1:0] idx;
  logic            found;

  // grant_idx falls back to rr_ptr+1 so the operand mux always has a defined lane.
  always_comb begin
    idx       = rr_ptr;
    found     = 1'b0;
    grant_idx = (rr_ptr == ID_W'(N_REQ - 1)) ? '0 : rr_ptr + ID_W'(1);
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign any_grant = found && en;
  assign grant     = any_grant ? (N_REQ'(1) << grant_idx) : '0;
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one combinational FP multiplier among N_REQ requesters; product held in a 1-entry result register.
// Latency 1 cycle handshake->rsp_valid; 1 op/cycle while rsp_ready high; no accepts while FULL and rsp_ready low.
// MUL_SHARE_ARB_PERF_EN adds perf_ops / perf_stall counters.
module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int FP_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [FP_W-1:0]       mul_a,
  output logic [FP_W-1:0]       mul_b,
  input  logic [FP_W-1:0]       mul_out,
  output logic                  rsp_valid,
  output logic [FP_W-1:0]       rsp_data,
  output logic [ID_W-1:0]       rsp_id,
`ifdef MUL_SHARE_ARB_PERF_EN
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall,
`endif
  input  logic                  rsp_ready
);
  import maxnet_pkg::*;

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            any_grant;
  logic            accept_en;

  assign accept_en = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && rsp_ready);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .en        (accept_en),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    mul_a = req_a[FP_W-1:0];
    mul_b = req_b[FP_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        mul_a = req_a[i*FP_W +: FP_W];
        mul_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (any_grant) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !any_grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A drain leaves rsp_data/rsp_id untouched; only a new grant overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= FP_W'(FP_ZERO);
      rsp_id   <= '0;
      rr_ptr   <= ID_W'(N_REQ - 1);
    end else if (any_grant) begin
      rsp_data <= mul_out;
      rsp_id   <= grant_idx;
      rr_ptr   <= grant_idx;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

`ifdef MUL_SHARE_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (any_grant) perf_ops <= perf_ops + 32'd1;
      if ((|req_valid) && !accept_en) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
